// File: rtl/nm_pkg.sv
// Shared definitions for the neuron_module host link: field widths, host
// command codes, the readout FSM encoding and the activity saturation helper.
package nm_pkg;

  localparam logic [7:0] cmd_idle  = 8'hFF;
  localparam logic [7:0] cmd_wract = 8'h01;
  localparam logic [7:0] cmd_rdact = 8'h02;

  localparam logic [7:0] HEADER_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    RD_IDLE = 3'd0,
    RD_HDR  = 3'd1,
    RD_REQ  = 3'd2,
    RD_SEND = 3'd3,
    RD_WTX  = 3'd4
  } rd_state_e;

  function automatic int neur_width(input int act_w, input int ref_w);
    return act_w + ref_w;
  endfunction

  // Clamp an activity value to one byte; values up to 255 pass through unchanged
  // so a byte written as {1'b0, byte} reads back identically.
  function automatic logic [7:0] sat_byte(input logic [31:0] act);
    logic [7:0] res;
    if (act > 32'd255) begin
      res = 8'hFF;
    end else begin
      res = act[7:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/neuron_readout_ctrl.sv
// Host-link readout: on rd_start, sends a header byte followed by one saturated
// activity byte per neuron, read in address order from neuron_module.
module neuron_readout_ctrl
  import nm_pkg::*;
#(
  parameter int         NEURON_NUMBER    = 256,
  parameter int         ACTIVITY_WIDTH   = 9,
  parameter int         REFRACTORY_WIDTH = 4,
  parameter logic [7:0] HEADER_BYTE      = HEADER_BYTE_DEFAULT,
  localparam int        NEUR_WIDTH       = neur_width(ACTIVITY_WIDTH, REFRACTORY_WIDTH),
  localparam int        AW               = $clog2(NEURON_NUMBER)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_start,
  input  logic                  rd_abort,
  output logic                  rd_busy,
  output logic                  frame_done,
  output logic                  nm_req,
  output logic                  nm_we,
  output logic [AW-1:0]         nm_addr,
  input  logic                  nm_ack,
  input  logic [NEUR_WIDTH-1:0] nm_rdata,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  input  logic                  tx_done
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(NEURON_NUMBER - 1);

  rd_state_e     state_r;
  logic          busy_r;
  logic          frame_done_r;
  logic          nm_req_r;
  logic          tx_start_r;
  logic          abort_r;
  logic          hdr_r;
  logic [AW-1:0] addr_r;
  logic [7:0]    tx_data_r;

  logic [31:0]   act_ext_s;
  logic [7:0]    sat_s;
  logic          last_s;
  logic          abort_hit_s;

  // Activity field extraction, saturation and frame-end / abort qualifiers.
  always_comb begin
    act_ext_s   = 32'(nm_rdata) >> REFRACTORY_WIDTH;
    sat_s       = sat_byte(act_ext_s);
    last_s      = (addr_r == LAST_ADDR);
    abort_hit_s = abort_r | rd_abort;
  end

  // Readout FSM with registered handshake outputs, address counter and tx byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= RD_IDLE;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      nm_req_r     <= 1'b0;
      tx_start_r   <= 1'b0;
      abort_r      <= 1'b0;
      hdr_r        <= 1'b0;
      addr_r       <= '0;
      tx_data_r    <= 8'h00;
    end else begin
      frame_done_r <= 1'b0;
      tx_start_r   <= 1'b0;
      // Sticky abort; the WTX exit below clears it when the frame stops.
      if ((state_r != RD_IDLE) && rd_abort) begin
        abort_r <= 1'b1;
      end
      case (state_r)
        RD_IDLE: begin
          abort_r <= 1'b0;
          if (rd_start) begin
            state_r   <= RD_HDR;
            busy_r    <= 1'b1;
            tx_data_r <= HEADER_BYTE;
            addr_r    <= '0;
            hdr_r     <= 1'b1;
          end
        end
        RD_HDR: begin
          tx_start_r <= 1'b1;
          state_r    <= RD_WTX;
        end
        RD_REQ: begin
          if (nm_ack) begin
            nm_req_r  <= 1'b0;
            tx_data_r <= sat_s;
            state_r   <= RD_SEND;
          end
        end
        RD_SEND: begin
          tx_start_r <= 1'b1;
          state_r    <= RD_WTX;
        end
        RD_WTX: begin
          if (tx_done) begin
            if (abort_hit_s) begin
              state_r <= RD_IDLE;
              busy_r  <= 1'b0;
              abort_r <= 1'b0;
            end else if (hdr_r) begin
              hdr_r    <= 1'b0;
              nm_req_r <= 1'b1;
              state_r  <= RD_REQ;
            end else if (last_s) begin
              state_r      <= RD_IDLE;
              busy_r       <= 1'b0;
              frame_done_r <= 1'b1;
            end else begin
              addr_r   <= addr_r + AW'(1'b1);
              nm_req_r <= 1'b1;
              state_r  <= RD_REQ;
            end
          end
        end
        default: begin
          state_r  <= RD_IDLE;
          busy_r   <= 1'b0;
          nm_req_r <= 1'b0;
          abort_r  <= 1'b0;
        end
      endcase
    end
  end

  assign rd_busy    = busy_r;
  assign frame_done = frame_done_r;
  assign nm_req     = nm_req_r;
  assign nm_we      = 1'b0;
  assign nm_addr    = addr_r;
  assign tx_start   = tx_start_r;
  assign tx_data    = tx_data_r;

endmodule

// File: tb/tb_neuron_readout_ctrl.sv
// Directed bench for neuron_readout_ctrl with a 4-neuron array, behavioural
// neuron_module / UART responders and immediate-assertion checks.
module tb_neuron_readout_ctrl;

  localparam int NN = 4;
  localparam int AW = 2;
  localparam int NW = 13;

  logic          clk = 1'b0;
  logic          reset;
  logic          rd_start;
  logic          rd_abort;
  logic          rd_busy;
  logic          frame_done;
  logic          nm_req;
  logic          nm_we;
  logic [AW-1:0] nm_addr;
  logic          nm_ack;
  logic [NW-1:0] nm_rdata;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          tx_done;

  int checks = 0;
  int errors = 0;

  logic [NW-1:0] nm_mem [NN];
  int            ack_delay = 0;
  int            tx_delay  = 0;
  logic [7:0]    tx_q   [$];
  logic [AW-1:0] addr_q [$];
  logic [7:0]    exp_q  [$];
  logic [7:0]    tx_hold;
  int            frame_done_cnt = 0;
  int            req_viol = 0;
  int            tx_viol  = 0;

  neuron_readout_ctrl #(
    .NEURON_NUMBER   (NN),
    .ACTIVITY_WIDTH  (9),
    .REFRACTORY_WIDTH(4),
    .HEADER_BYTE     (8'hA5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rd_start  (rd_start),
    .rd_abort  (rd_abort),
    .rd_busy   (rd_busy),
    .frame_done(frame_done),
    .nm_req    (nm_req),
    .nm_we     (nm_we),
    .nm_addr   (nm_addr),
    .nm_ack    (nm_ack),
    .nm_rdata  (nm_rdata),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_done   (tx_done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // neuron_module model: acks each request after ack_delay cycles
  always begin
    @(posedge clk); #1;
    if (nm_req === 1'b1) begin
      for (int i = 0; i < ack_delay; i++) begin
        @(posedge clk); #1;
        if (nm_req !== 1'b1) req_viol++;
      end
      nm_rdata = nm_mem[nm_addr];
      nm_ack   = 1'b1;
      addr_q.push_back(nm_addr);
      @(posedge clk); #1;
      nm_ack   = 1'b0;
      nm_rdata = '0;
      if (nm_req !== 1'b0) req_viol++;
    end
  end

  // UART model: logs each byte, holds tx_done off for tx_delay cycles
  always begin
    @(posedge clk); #1;
    if (tx_start === 1'b1) begin
      tx_hold = tx_data;
      tx_q.push_back(tx_data);
      @(posedge clk); #1;
      if (tx_start !== 1'b0) tx_viol++;
      for (int i = 0; i < tx_delay; i++) begin
        if (tx_data !== tx_hold || nm_req !== 1'b0 || tx_start !== 1'b0) tx_viol++;
        @(posedge clk); #1;
      end
      tx_done = 1'b1;
      @(posedge clk); #1;
      tx_done = 1'b0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (frame_done === 1'b1) frame_done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    tx_q.delete();
    addr_q.delete();
    frame_done_cnt = 0;
    req_viol = 0;
    tx_viol  = 0;
  endtask

  task automatic start_frame(input string tag, input logic with_abort);
    rd_start = 1'b1;
    rd_abort = with_abort;
    @(posedge clk); #1;
    rd_start = 1'b0;
    rd_abort = 1'b0;
    chk({tag, "_busy"}, 32'(rd_busy), 32'd1);
    chk({tag, "_txs_n1"}, 32'(tx_start), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_txs_n2"}, 32'(tx_start), 32'd1);
    chk({tag, "_hdr"}, 32'(tx_data), 32'h0000_00A5);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (rd_busy === 1'b1 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_idle"}, 32'(rd_busy), 32'd0);
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic compare_frame(input string tag);
    chk({tag, "_len"}, 32'(tx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      chk($sformatf("%s_b%0d", tag, i), (i < tx_q.size()) ? 32'(tx_q[i]) : 32'hDEAD, 32'(exp_q[i]));
    end
  endtask

  task automatic compare_addrs(input string tag, input int n);
    chk({tag, "_nreads"}, 32'(addr_q.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_a%0d", tag, i), (i < addr_q.size()) ? 32'(addr_q[i]) : 32'hDEAD, 32'(i));
    end
  endtask

  task automatic load_set_a();
    nm_mem[0] = {9'd3,   4'hA};
    nm_mem[1] = {9'd0,   4'hA};
    nm_mem[2] = {9'd255, 4'hA};
    nm_mem[3] = {9'd256, 4'hA};
    exp_q = '{8'hA5, 8'h03, 8'h00, 8'hFF, 8'hFF};
  endtask

  task automatic load_set_b();
    nm_mem[0] = {1'b0, 8'h7E, 4'd0};
    nm_mem[1] = {9'h1FF, 4'h5};
    nm_mem[2] = {9'h080, 4'hF};
    nm_mem[3] = {9'h001, 4'h5};
    exp_q = '{8'hA5, 8'h7E, 8'hFF, 8'h80, 8'h01};
  endtask

  initial begin
    int n;
    reset    = 1'b1;
    rd_start = 1'b0;
    rd_abort = 1'b0;
    nm_ack   = 1'b0;
    tx_done  = 1'b0;
    nm_rdata = '0;
    load_set_a();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(rd_busy), 32'd0);
    chk("rst_fdone", 32'(frame_done), 32'd0);
    chk("rst_req", 32'(nm_req), 32'd0);
    chk("rst_txs", 32'(tx_start), 32'd0);
    chk("rst_addr", 32'(nm_addr), 32'd0);
    chk("rst_txd", 32'(tx_data), 32'd0);
    chk("rst_we", 32'(nm_we), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // 1: instant responders, saturation boundaries 255/256
    clear_logs();
    start_frame("t1", 1'b0);
    wait_idle("t1", 500);
    compare_frame("t1");
    compare_addrs("t1", 4);
    chk("t1_fdone", 32'(frame_done_cnt), 32'd1);

    // 2: slow ack, request must hold until the ack cycle only
    ack_delay = 5;
    load_set_b();
    clear_logs();
    start_frame("t2", 1'b0);
    wait_idle("t2", 1000);
    compare_frame("t2");
    compare_addrs("t2", 4);
    chk("t2_reqviol", 32'(req_viol), 32'd0);
    chk("t2_fdone", 32'(frame_done_cnt), 32'd1);

    // 3: slow UART, tx_data stable and no new request during the wait
    ack_delay = 0;
    tx_delay  = 20;
    load_set_a();
    clear_logs();
    start_frame("t3", 1'b0);
    wait_idle("t3", 2000);
    compare_frame("t3");
    compare_addrs("t3", 4);
    chk("t3_txviol", 32'(tx_viol), 32'd0);
    chk("t3_fdone", 32'(frame_done_cnt), 32'd1);

    // 4: rd_start while busy is neither a restart nor queued
    tx_delay = 3;
    load_set_b();
    clear_logs();
    start_frame("t4", 1'b0);
    repeat (12) @(posedge clk);
    #1;
    chk("t4_busy_mid", 32'(rd_busy), 32'd1);
    rd_start = 1'b1;
    @(posedge clk); #1;
    rd_start = 1'b0;
    wait_idle("t4", 1000);
    repeat (20) @(posedge clk);
    #1;
    chk("t4_busy_after", 32'(rd_busy), 32'd0);
    compare_frame("t4");
    compare_addrs("t4", 4);
    chk("t4_fdone", 32'(frame_done_cnt), 32'd1);

    // 5: abort while the read of addr 1 is outstanding
    ack_delay = 5;
    tx_delay  = 1;
    load_set_a();
    clear_logs();
    start_frame("t5", 1'b0);
    n = 0;
    while (!(nm_req === 1'b1 && nm_addr === 2'd1) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t5_reach_req1", 32'(n < 500), 32'd1);
    rd_abort = 1'b1;
    @(posedge clk); #1;
    rd_abort = 1'b0;
    wait_idle("t5", 500);
    exp_q = '{8'hA5, 8'h03, 8'h00};
    compare_frame("t5");
    compare_addrs("t5", 2);
    chk("t5_fdone", 32'(frame_done_cnt), 32'd0);
    ack_delay = 0;
    load_set_a();
    clear_logs();
    start_frame("t5r", 1'b0);
    wait_idle("t5r", 500);
    compare_frame("t5r");
    compare_addrs("t5r", 4);
    chk("t5r_fdone", 32'(frame_done_cnt), 32'd1);

    // 6: reset while waiting on the UART
    tx_delay = 20;
    load_set_b();
    clear_logs();
    start_frame("t6", 1'b0);
    n = 0;
    while (tx_q.size() < 2 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t6_reach_wtx", 32'(tx_q.size()), 32'd2);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("t6_busy", 32'(rd_busy), 32'd0);
    chk("t6_fdone0", 32'(frame_done), 32'd0);
    chk("t6_req", 32'(nm_req), 32'd0);
    chk("t6_txs", 32'(tx_start), 32'd0);
    chk("t6_addr", 32'(nm_addr), 32'd0);
    chk("t6_txd", 32'(tx_data), 32'd0);
    reset = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("t6_quiet_len", 32'(tx_q.size()), 32'd2);
    chk("t6_quiet_busy", 32'(rd_busy), 32'd0);
    chk("t6_quiet_fdone", 32'(frame_done_cnt), 32'd0);
    tx_delay = 0;
    clear_logs();
    start_frame("t6r", 1'b0);
    wait_idle("t6r", 500);
    compare_frame("t6r");
    compare_addrs("t6r", 4);
    chk("t6r_fdone", 32'(frame_done_cnt), 32'd1);

    // 7: abort in IDLE ignored; start+abort together starts a full frame
    load_set_a();
    clear_logs();
    rd_abort = 1'b1;
    @(posedge clk); #1;
    rd_abort = 1'b0;
    chk("t7_idle_abort", 32'(rd_busy), 32'd0);
    start_frame("t7", 1'b1);
    wait_idle("t7", 500);
    compare_frame("t7");
    chk("t7_fdone", 32'(frame_done_cnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
